nts_engine_scheduler: RTL
=========================

// Module: nts_engine_scheduler
// PURPOSE
//  Shares one upstream dispatcher (packet FIFO + available/discard handshake) among ENGINES
//  nts_engine instances. Picks an idle engine round-robin, routes the FIFO read port to it for
//  one packet, then releases the packet upstream. Sits between the RX dispatcher and the engine array.
// PARAMETERS
//  ENGINES        4    number of engine instances served (2..16)
//  ENGINE_IDX_W   2    width of engine index, = clog2(ENGINES)
//  TIMEOUT_CYCLES 255  max cycles in FORWARD before abort (1..255, 8-bit counter)
// PORTS
//  i_clk                         in   1         clock
//  i_areset                      in   1         reset, asynchronous, active-high
//  i_dispatch_packet_available   in   1         upstream has a complete packet
//  o_dispatch_packet_read_discard out 1         1-cycle pulse: packet consumed/dropped
//  i_dispatch_data_valid         in   8         byte-valid mask of last word
//  i_dispatch_fifo_empty         in   1         upstream FIFO empty
//  o_dispatch_fifo_rd_en         out  1         upstream FIFO read strobe
//  i_dispatch_fifo_rd_data       in   64        upstream FIFO data
//  i_engine_busy                 in   ENGINES   per-engine o_busy
//  o_engine_packet_available     out  ENGINES   per-engine packet_available (one-hot or 0)
//  o_engine_fifo_empty           out  ENGINES   per-engine fifo_empty (1 unless granted)
//  i_engine_fifo_rd_en           in   ENGINES   per-engine fifo_rd_en
//  o_engine_data_valid           out  8         broadcast of i_dispatch_data_valid
//  o_engine_fifo_rd_data         out  64        broadcast of i_dispatch_fifo_rd_data
//  o_grant                       out  ENGINE_IDX_W  currently/last granted engine
//  o_busy                        out  1         scheduler not in IDLE
//  o_packets_forwarded           out  32        count of successful hand-overs (wraps)
//  o_timeouts                    out  16        count of aborted hand-overs (saturates 0xFFFF)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, o_grant 0, counters 0, o_busy 0, discard 0; engine
//   available all 0, engine fifo_empty all 1, o_dispatch_fifo_rd_en 0.
//  States: IDLE -> SELECT -> FORWARD -> RELEASE -> WAIT_CLEAR -> IDLE.
//  IDLE: if available && !fifo_empty -> SELECT next cycle.
//  SELECT: first engine with busy==0 searching ptr, ptr+1, .. mod ENGINES; found -> latch
//   grant, clear timeout ctr, FORWARD. None idle -> stay (backpressure, no drop).
//  FORWARD: available[g]=i_dispatch_packet_available, fifo_empty[g]=i_dispatch_fifo_empty,
//   others 0/1. o_dispatch_fifo_rd_en = i_engine_fifo_rd_en[g] & !i_dispatch_fifo_empty
//   (combinational, zero latency); rd_en from non-granted engines ignored always.
//   Exit: i_engine_busy[g]==1 && i_dispatch_fifo_empty -> RELEASE, forwarded+1.
//   Timeout ctr +1 per cycle; reaching TIMEOUT_CYCLES -> RELEASE, timeouts+1 (abort).
//   Both same cycle: success wins.
//  RELEASE: discard=1 exactly 1 cycle; all engine available 0; ptr <= (g+1) mod ENGINES.
//  WAIT_CLEAR: hold until i_dispatch_packet_available==0 -> IDLE (no double-consume).
//  Upstream available drop in FORWARD before exit: treat as abort -> RELEASE, timeouts+1.
//  Granted engine busy already 1 in SELECT cycle: not selectable; ties resolved only by ptr.
//  Async reset mid-FORWARD: all outputs to reset values immediately; no discard issued.
//  Engine-side discard outputs are not inputs here; engine completion seen via busy only.
// STRUCTURE
//  Shared constants file: state encodings (3-bit), TIMEOUT default, counter widths.
//  Sub-module nts_rr_select: combinational (req vector, ptr) -> (found, index), rotate-priority.
//  Top: FSM, grant/ptr regs, timeout ctr, stat counters, per-engine muxing.
// TESTING
//  4 engines idle, one 3-word packet -> grant 0, 3 rd_en pulses pass, 1 discard, forwarded=1.
//  Four back-to-back packets, engines stay busy -> grants 0,1,2,3, ptr wraps to 0.
//  All busy, packet waits 50 cycles, engine 2 frees -> grant 2, no rd_en before grant.
//  Granted engine never raises busy, TIMEOUT_CYCLES=10 -> discard at cycle 10, timeouts=1.
//  rd_en from non-granted engine 3 during FORWARD of engine 1 -> o_dispatch_fifo_rd_en 0.
//  Assert i_areset mid-FORWARD -> outputs reset values same cycle, next packet gets grant 0.

Source files
------------

// File: rtl/nts_engine_scheduler_pkg.sv
// Shared types and constants for the engine scheduler: FSM encoding, counter widths
// and the saturating increment used by the abort statistic.
package nts_engine_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SELECT     = 3'd1,
        ST_FORWARD    = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } sched_state_e;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TMO_CTR_W       = 8;
    localparam int FWD_CNT_W       = 32;
    localparam int TMO_CNT_W       = 16;

    function automatic logic [TMO_CNT_W-1:0] sat_inc16(input logic [TMO_CNT_W-1:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nts_rr_select.sv
// Rotating-priority search: returns the first requesting index at or after ptr_i,
// wrapping modulo N.
module nts_rr_select
    import nts_engine_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);

    logic [IDX_W:0]   cand_s;
    logic [IDX_W-1:0] idx_s;

    // Walk from the pointer; the first hit wins, later hits are masked by found_o.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        cand_s  = '0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N)) begin
                cand_s = cand_s - (IDX_W+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            idx_s = cand_s[IDX_W-1:0];
            if (!found_o && req_i[idx_s]) begin
                found_o = 1'b1;
                index_o = idx_s;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/nts_engine_scheduler.sv
// Shares one upstream packet dispatcher among ENGINES engines: round-robin pick of an idle
// engine, per-packet routing of the FIFO read port, then release of the packet upstream.
module nts_engine_scheduler
    import nts_engine_scheduler_pkg::*;
#(
    parameter int ENGINES        = 4,
    parameter int ENGINE_IDX_W   = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_areset,
    input  logic                    i_dispatch_packet_available,
    output logic                    o_dispatch_packet_read_discard,
    input  logic [7:0]              i_dispatch_data_valid,
    input  logic                    i_dispatch_fifo_empty,
    output logic                    o_dispatch_fifo_rd_en,
    input  logic [63:0]             i_dispatch_fifo_rd_data,
    input  logic [ENGINES-1:0]      i_engine_busy,
    output logic [ENGINES-1:0]      o_engine_packet_available,
    output logic [ENGINES-1:0]      o_engine_fifo_empty,
    input  logic [ENGINES-1:0]      i_engine_fifo_rd_en,
    output logic [7:0]              o_engine_data_valid,
    output logic [63:0]             o_engine_fifo_rd_data,
    output logic [ENGINE_IDX_W-1:0] o_grant,
    output logic                    o_busy,
    output logic [FWD_CNT_W-1:0]    o_packets_forwarded,
    output logic [TMO_CNT_W-1:0]    o_timeouts
);

    localparam logic [TMO_CTR_W-1:0] TMO_LIMIT = TMO_CTR_W'(TIMEOUT_CYCLES);

    sched_state_e              state_q, state_d;
    logic [ENGINE_IDX_W-1:0]   ptr_q, ptr_d;
    logic [ENGINE_IDX_W-1:0]   grant_q, grant_d;
    logic [TMO_CTR_W-1:0]      tmo_ctr_q, tmo_ctr_d;
    logic [FWD_CNT_W-1:0]      fwd_cnt_q, fwd_cnt_d;
    logic [TMO_CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic                      sel_found_s;
    logic [ENGINE_IDX_W-1:0]   sel_idx_s;
    logic                      fwd_s;
    logic                      engine_done_s;
    logic [TMO_CTR_W-1:0]      tmo_next_s;
    logic [ENGINE_IDX_W-1:0]   grant_next_s;

    nts_rr_select #(
        .N     (ENGINES),
        .IDX_W (ENGINE_IDX_W)
    ) u_rr_select (
        .req_i   (~i_engine_busy),
        .ptr_i   (ptr_q),
        .found_o (sel_found_s),
        .index_o (sel_idx_s)
    );

    assign fwd_s         = (state_q == ST_FORWARD);
    assign engine_done_s = i_engine_busy[grant_q] & i_dispatch_fifo_empty;
    assign tmo_next_s    = tmo_ctr_q + 8'd1;
    assign grant_next_s  = (grant_q == ENGINE_IDX_W'(ENGINES - 1)) ? '0
                                                                   : grant_q + ENGINE_IDX_W'(1);

    // State and statistics registers; async reset lands every output at its idle value.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            tmo_ctr_q <= '0;
            fwd_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            tmo_ctr_q <= tmo_ctr_d;
            fwd_cnt_q <= fwd_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Next-state logic; a completed hand-over takes priority over any abort cause.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        tmo_ctr_d = tmo_ctr_q;
        fwd_cnt_d = fwd_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (sel_found_s) begin
                    grant_d   = sel_idx_s;
                    tmo_ctr_d = '0;
                    state_d   = ST_FORWARD;
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_FORWARD: begin
                tmo_ctr_d = tmo_next_s;
                if (engine_done_s) begin
                    fwd_cnt_d = fwd_cnt_q + 32'd1;
                    state_d   = ST_RELEASE;
                end else if (!i_dispatch_packet_available || (tmo_next_s == TMO_LIMIT)) begin
                    tmo_cnt_d = sat_inc16(tmo_cnt_q);
                    state_d   = ST_RELEASE;
                end else begin
                    state_d = ST_FORWARD;
                end
            end
            ST_RELEASE: begin
                ptr_d   = grant_next_s;
                state_d = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                // Upstream must deassert before we look again, or the same packet is taken twice.
                if (!i_dispatch_packet_available) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route the dispatcher handshake to the granted engine only; others see an empty FIFO.
    always_comb begin
        o_engine_packet_available = '0;
        o_engine_fifo_empty       = '1;
        for (int e = 0; e < ENGINES; e++) begin
            o_engine_packet_available[e] = fwd_s && (grant_q == ENGINE_IDX_W'(e))
                                           && i_dispatch_packet_available;
            o_engine_fifo_empty[e]       = !(fwd_s && (grant_q == ENGINE_IDX_W'(e)))
                                           || i_dispatch_fifo_empty;
        end
    end

    assign o_dispatch_fifo_rd_en          = fwd_s & i_engine_fifo_rd_en[grant_q] & ~i_dispatch_fifo_empty;
    assign o_dispatch_packet_read_discard = (state_q == ST_RELEASE);
    assign o_engine_data_valid            = i_dispatch_data_valid;
    assign o_engine_fifo_rd_data          = i_dispatch_fifo_rd_data;
    assign o_grant                        = grant_q;
    assign o_busy                         = (state_q != ST_IDLE);
    assign o_packets_forwarded            = fwd_cnt_q;
    assign o_timeouts                     = tmo_cnt_q;

endmodule
